// File: rtl/peripheral_mpram_ahb3_slave.sv
// peripheral_mpram_ahb3_slave: AHB3-Lite slave driving a 1R1W byte-enabled RAM; define MPRAM_AHB3_BYPASS_EN for zero-wait collision reads
module peripheral_mpram_ahb3_slave #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int ABITS      = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    hsel_i,
  input  logic [HADDR_SIZE-1:0]   haddr_i,
  input  logic [HDATA_SIZE-1:0]   hwdata_i,
  output logic [HDATA_SIZE-1:0]   hrdata_o,
  input  logic                    hwrite_i,
  input  logic [2:0]              hsize_i,
  input  logic [2:0]              hburst_i,
  input  logic [3:0]              hprot_i,
  input  logic [1:0]              htrans_i,
  input  logic                    hmastlock_i,
  input  logic                    hready_i,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  output logic [ABITS-1:0]        mem_waddr_o,
  output logic [HDATA_SIZE-1:0]   mem_din_o,
  output logic                    mem_we_o,
  output logic [HDATA_SIZE/8-1:0] mem_be_o,
  output logic [ABITS-1:0]        mem_raddr_o,
  input  logic [HDATA_SIZE-1:0]   mem_dout_i
);
  localparam int NB = HDATA_SIZE / 8;
  localparam int B  = $clog2(NB);
`ifdef MPRAM_AHB3_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WRITE, READ, RSTALL, ERR1, ERR2} state_t;
  state_t state, state_nxt;
  logic [ABITS-1:0] addr, waddr_q, raddr_q;
  logic [NB-1:0] be, be_q;
  logic [B-1:0] off;
  logic [HDATA_SIZE-1:0] rdata;
  logic take, bad, rd_acc, coll, unused;
  assign unused = ^{hburst_i, hprot_i, hmastlock_i, haddr_i};
  assign addr = haddr_i[ABITS+B-1:B];
  assign take = hsel_i & hready_i & htrans_i[1] & hreadyout_o;
  assign bad = hsize_i > 3'(B);
  assign rd_acc = take & ~hwrite_i & ~bad;
  assign coll = state == WRITE && addr == waddr_q;
  // naturally aligned lane mask: low address bits below the size boundary are dropped
  always_comb begin
    off = haddr_i[B-1:0] & ~B'((1 << hsize_i) - 1);
    be = NB'((1 << (1 << hsize_i)) - 1) << off;
  end
  // next state is decided by the accepted transfer; the two stall states advance on their own
  always_comb begin
    state_nxt = IDLE;
    if (state == ERR1) state_nxt = ERR2;
    else if (state == RSTALL) state_nxt = READ;
    else if (take) state_nxt = bad ? ERR1 : hwrite_i ? WRITE : (coll && !BYP) ? RSTALL : READ;
  end
  // state and address-phase registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      waddr_q <= '0;
      be_q <= '0;
      raddr_q <= '0;
    end else begin
      state <= state_nxt;
      if (take) waddr_q <= addr;
      if (take) be_q <= be;
      if (rd_acc) raddr_q <= addr;
    end
  end
`ifdef MPRAM_AHB3_BYPASS_EN
  logic [HDATA_SIZE-1:0] wdata_q;
  logic [NB-1:0] wbe_q;
  logic byp_q;
  // capture the write that a colliding read must see, since the RAM returns old data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdata_q <= '0;
      wbe_q <= '0;
      byp_q <= 1'b0;
    end else begin
      if (mem_we_o) wdata_q <= hwdata_i;
      if (mem_we_o) wbe_q <= be_q;
      byp_q <= rd_acc & coll;
    end
  end
  // overlay the freshly written lanes on the stale RAM word
  always_comb begin
    rdata = mem_dout_i;
    for (int i = 0; i < NB; i++) if (byp_q && wbe_q[i]) rdata[8*i +: 8] = wdata_q[8*i +: 8];
  end
`else
  assign rdata = mem_dout_i;
`endif
  assign hreadyout_o = !(state == ERR1 || state == RSTALL);
  assign hresp_o = state == ERR1 || state == ERR2;
  assign hrdata_o = state == READ ? rdata : '0;
  assign mem_we_o = state == WRITE;
  assign mem_be_o = mem_we_o ? be_q : '0;
  assign mem_waddr_o = waddr_q;
  assign mem_din_o = hwdata_i;
  assign mem_raddr_o = rd_acc ? addr : raddr_q;
endmodule

// File: tb/tb_peripheral_mpram_ahb3_slave.sv
// tb_peripheral_mpram_ahb3_slave: directed and random AHB traffic against a byte-array memory model
module tb_peripheral_mpram_ahb3_slave;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic hsel, hwrite, hmastlock, hready, hreadyout, hresp, mem_we;
  logic [31:0] haddr, hwdata, hrdata, mem_din, mem_dout;
  logic [2:0] hsize, hburst;
  logic [3:0] hprot, mem_be;
  logic [1:0] htrans;
  logic [9:0] mem_waddr, mem_raddr;
  assign hready = hreadyout;

  peripheral_mpram_ahb3_slave dut (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .hwdata_i(hwdata),
    .hrdata_o(hrdata), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
    .hprot_i(hprot), .htrans_i(htrans), .hmastlock_i(hmastlock), .hready_i(hready),
    .hreadyout_o(hreadyout), .hresp_o(hresp), .mem_waddr_o(mem_waddr), .mem_din_o(mem_din),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_raddr_o(mem_raddr), .mem_dout_i(mem_dout)
  );

  // RAM behind the slave: byte-enabled write, registered read returning old data
  logic [31:0] ram [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we) for (int i = 0; i < 4; i++) if (mem_be[i]) ram[mem_waddr][8*i +: 8] <= mem_din[8*i +: 8];
    mem_dout <= ram[mem_raddr];
  end

  typedef struct {
    bit sel;
    logic [1:0] trans;
    bit wr;
    logic [2:0] size;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;
  tr_t q[$];
  logic [7:0] mem_b [4096];
  int n_chk = 0, n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic tr_t mk(bit sel, logic [1:0] trans, bit wr, logic [2:0] size, logic [31:0] addr, logic [31:0] data);
    tr_t t;
    t.sel = sel; t.trans = trans; t.wr = wr; t.size = size; t.addr = addr; t.data = data;
    return t;
  endfunction
  function automatic bit act(tr_t t); return t.sel && t.trans[1]; endfunction
  function automatic bit bad(tr_t t); return act(t) && t.size > 3'd2; endfunction
  function automatic bit wr_ok(tr_t t); return act(t) && t.wr && t.size <= 3'd2; endfunction
  function automatic bit rd_ok(tr_t t); return act(t) && !t.wr && t.size <= 3'd2; endfunction
  function automatic logic [31:0] wa(logic [31:0] a); return {22'd0, a[11:2]}; endfunction
  function automatic logic [31:0] model_rd(logic [31:0] a);
    int b = int'(a[11:2]) * 4;
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction
  task automatic model_wr(tr_t t, output logic [31:0] be);
    int n = 1 << t.size;
    int base = int'(t.addr[11:0]) & ~(n - 1);
    be = 0;
    for (int k = 0; k < n; k++) begin
      mem_b[base+k] = t.data[8*((base+k)%4) +: 8];
      be[(base+k)%4] = 1'b1;
    end
  endtask

  // pipelined master: address phase of one entry overlaps the data phase of the previous
  task automatic run_q();
    tr_t dp, prv, ap;
    int waits, exp_w;
    logic [31:0] be;
    dp = mk(0, 2'd0, 0, 3'd0, 0, 0);
    prv = dp;
    q.push_back(dp);
    q.push_back(dp);
    while (q.size() > 0) begin
      ap = q.pop_front();
      hsel = ap.sel; htrans = ap.trans; hwrite = ap.wr; hsize = ap.size; haddr = ap.addr; hwdata = dp.data;
      waits = 0;
      @(negedge clk);
      while (!hreadyout && waits < 4) begin
        if (bad(dp)) check("err1_resp", 32'(hresp), 1);
        else if (rd_ok(dp)) check("stall_raddr", 32'(mem_raddr), wa(dp.addr));
        check("stall_we", 32'(mem_we), 0);
        waits++;
        @(negedge clk);
      end
      exp_w = int'(wr_ok(prv) && wa(prv.addr) == wa(dp.addr));
`ifdef MPRAM_AHB3_BYPASS_EN
      exp_w = 0;
`endif
      if (bad(dp)) begin
        check("err_waits", 32'(waits), 1);
        check("err2_resp", 32'(hresp), 1);
        check("err_we", 32'(mem_we), 0);
        check("err_rdata", hrdata, 0);
      end else if (wr_ok(dp)) begin
        model_wr(dp, be);
        check("wr_waits", 32'(waits), 0);
        check("wr_we", 32'(mem_we), 1);
        check("wr_be", 32'(mem_be), be);
        check("wr_waddr", 32'(mem_waddr), wa(dp.addr));
        check("wr_din", mem_din, dp.data);
        check("wr_resp", 32'(hresp), 0);
        check("wr_rdata", hrdata, 0);
      end else if (rd_ok(dp)) begin
        check("rd_waits", 32'(waits), 32'(exp_w));
        check("rd_data", hrdata, model_rd(dp.addr));
        check("rd_resp", 32'(hresp), 0);
      end else begin
        check("idle_waits", 32'(waits), 0);
        check("idle_resp", 32'(hresp), 0);
        check("idle_we", 32'(mem_we), 0);
        check("idle_rdata", hrdata, 0);
      end
      if (rd_ok(ap) && hreadyout) check("rd_raddr", 32'(mem_raddr), wa(ap.addr));
      @(posedge clk);
      #1;
      prv = dp;
      dp = ap;
    end
  endtask

  initial begin
    int r;
    hsel = 0; htrans = 0; hwrite = 0; hsize = 0; haddr = 0; hwdata = 0;
    hburst = 0; hprot = 4'b0011; hmastlock = 0;
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'h0;
    #2;
    check("rst_hreadyout", 32'(hreadyout), 1);
    check("rst_hresp", 32'(hresp), 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_be", 32'(mem_be), 0);
    check("rst_waddr", 32'(mem_waddr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // reset asserted in the middle of a write data phase
    hsel = 1; htrans = 2; hwrite = 1; hsize = 2; haddr = 32'h10;
    @(posedge clk);
    #1 htrans = 0; hwdata = 32'hCAFEF00D;
    #1 check("t1_we_before", 32'(mem_we), 1);
    rst = 1;
    #1;
    check("t1_hreadyout", 32'(hreadyout), 1);
    check("t1_hresp", 32'(hresp), 0);
    check("t1_hrdata", hrdata, 0);
    check("t1_we", 32'(mem_we), 0);
    check("t1_be", 32'(mem_be), 0);
    check("t1_waddr", 32'(mem_waddr), 0);
    @(posedge clk);
    #1 rst = 0;
    q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h10, 0));
    run_q();
    // word write, idle, read back
    q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h40, 32'h12345678));
    q.push_back(mk(1, 2'd0, 0, 3'd0, 32'h0, 0));
    q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h40, 0));
    // byte then halfword merge
    q.push_back(mk(1, 2'd2, 1, 3'd0, 32'h43, 32'hAB000000));
    q.push_back(mk(1, 2'd2, 1, 3'd1, 32'h40, 32'h0000CDEF));
    q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h40, 0));
    // write immediately followed by a read of the same word
    q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h80, 32'hDEADBEEF));
    q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h80, 0));
    // illegal size, then a normal read accepted in the second error cycle
    q.push_back(mk(1, 2'd2, 1, 3'd3, 32'h40, 32'hFFFFFFFF));
    q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h40, 0));
    run_q();
    check("t3_value", model_rd(32'h40), 32'hAB34CDEF);
    // INCR burst with a BUSY beat, then read-back burst
    q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h100, $urandom));
    q.push_back(mk(1, 2'd3, 1, 3'd2, 32'h104, $urandom));
    q.push_back(mk(1, 2'd1, 1, 3'd2, 32'h108, $urandom));
    q.push_back(mk(1, 2'd3, 1, 3'd2, 32'h108, $urandom));
    q.push_back(mk(1, 2'd3, 1, 3'd2, 32'h10C, $urandom));
    q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h100, 0));
    for (int i = 1; i < 4; i++) q.push_back(mk(1, 2'd3, 0, 3'd2, 32'h100 + 32'(4*i), 0));
    run_q();
    // random traffic over a small window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      tr_t t;
      r = $urandom_range(0, 9);
      t.sel = $urandom_range(0, 19) != 0;
      t.trans = r == 0 ? 2'd0 : r == 1 ? 2'd1 : 2'($urandom_range(2, 3));
      t.wr = $urandom_range(0, 1) != 0;
      r = $urandom_range(0, 19);
      t.size = r < 19 ? 3'(r % 3) : 3'($urandom_range(3, 7));
      t.addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      t.data = $urandom;
      q.push_back(t);
    end
    run_q();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/peripheral_mpram_ahb3_slave.md
Name: peripheral_mpram_ahb3_slave

Overview:
AHB3-Lite slave that turns bus transfers into write-port and read-port cycles of a 1R1W inferred RAM. The RAM has byte-enabled writes and a registered read with 1-cycle latency and read-old-data behaviour. The block sits between the AHB interconnect and the RAM instance inside the ahb3 MPRAM peripheral. It handles byte-lane generation, zero-wait writes and reads, write-to-read collisions and ERROR responses.

Parameters:
HADDR_SIZE, 32, AHB address width
HDATA_SIZE, 32, AHB data width; equals RAM data width; power of 2, 32 or 64
ABITS, 10, RAM word-address width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
hsel_i  in  1  slave select
haddr_i  in  HADDR_SIZE  address
hwdata_i  in  HDATA_SIZE  write data (data phase)
hrdata_o  out  HDATA_SIZE  read data
hwrite_i  in  1  1 = write
hsize_i  in  3  transfer size
hburst_i  in  3  burst type (ignored; every beat is decoded independently)
hprot_i  in  4  protection (ignored)
htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hmastlock_i  in  1  ignored
hready_i  in  1  bus ready
hreadyout_o  out  1  slave ready
hresp_o  out  1  0 = OKAY, 1 = ERROR
mem_waddr_o  out  ABITS  RAM write word address
mem_din_o  out  HDATA_SIZE  RAM write data
mem_we_o  out  1  RAM write enable
mem_be_o  out  HDATA_SIZE/8  RAM byte enables
mem_raddr_o  out  ABITS  RAM read word address
mem_dout_i  in  HDATA_SIZE  RAM read data, valid 1 cycle after mem_raddr_o is sampled

Behaviour:
- Reset values:
  - hreadyout_o=1, hresp_o=0, hrdata_o=0.
  - mem_we_o=0, mem_be_o=0, mem_waddr_o=0.
  - State = IDLE; pending write discarded.
  - Reset mid-transfer aborts the transfer with no RAM write.
- Accept: hsel_i & hready_i & htrans_i[1].
- Word address: haddr_i[ABITS+B-1:B], with B=log2(HDATA_SIZE/8). Upper address bits are ignored.
- Byte enables from hsize_i and haddr_i[B-1:0], naturally aligned:
  - byte sets 1 lane; halfword sets 2 lanes; word sets 4 lanes; doubleword (64-bit only) sets 8 lanes.
  - Misaligned low address bits are masked down to the size boundary.
- Illegal size: hsize_i > B gives an ERROR response. No RAM access.
- IDLE/BUSY, or accept while not selected: OKAY, zero wait, no RAM access.
- States: IDLE, WRITE, READ, RSTALL, ERR1, ERR2.
- WRITE (data phase):
  - mem_we_o=1 combinationally; mem_waddr_o/mem_be_o from address-phase registers; mem_din_o=hwdata_i.
  - hreadyout_o=1, so the write takes zero wait states.
- READ:
  - mem_raddr_o is driven combinationally from haddr_i during the accepted address phase.
  - In the data phase, hrdata_o=mem_dout_i and hreadyout_o=1.
  - Outside the READ data phase, hrdata_o=0.
- Collision: read accepted while in WRITE data phase with an equal word address. The RAM returns old data.
  - Without the feature: go to RSTALL. hreadyout_o=0 for exactly 1 cycle while mem_raddr_o re-drives the registered address. Next cycle return mem_dout_i with hreadyout_o=1.
- Back-to-back writes to the same address: each written in its own data phase, in bus order.
- ERROR is two-cycle:
  - ERR1: hresp_o=1, hreadyout_o=0.
  - ERR2: hresp_o=1, hreadyout_o=1.
  - A new transfer accepted in ERR2 is decoded normally.
- Next state is taken from the transfer accepted when hreadyout_o & hready_i; otherwise go to IDLE.
- mem_raddr_o holds its last value when no read is accepted.

Optional Feature:
MPRAM_AHB3_BYPASS_EN
- Defined:
  - Collision reads take zero wait states, and RSTALL is unreachable.
  - The pending write data and byte enables are registered.
  - hrdata_o returns mem_dout_i with the written lanes replaced by the registered write data.
- Undefined: collision reads take the 1-cycle RSTALL path described above.

Test Plan:
1. Reset asserted mid-WRITE data phase, then release, then read of 0x10 -> no write occurred; hreadyout_o=1, hresp_o=0, hrdata_o=0 during reset; read returns the preloaded 0x00000000.
2. Word write 0x12345678 to 0x40, IDLE, read 0x40 -> mem_we_o=1 with mem_be_o=4'b1111 and mem_waddr_o=0x10; read returns 0x12345678 with zero wait states.
3. Byte write 0xAB to 0x43, halfword write 0xCDEF to 0x40, read 0x40 -> be=4'b1000 then 4'b0011; read returns 0xAB34CDEF.
4. Word write 0xDEADBEEF to 0x80 immediately followed by read 0x80 -> without the macro, one cycle with hreadyout_o=0 then 0xDEADBEEF; with the macro, 0xDEADBEEF with zero waits.
5. NONSEQ with hsize=3'b011 on the 32-bit bus -> hresp_o=1/hreadyout_o=0, then hresp_o=1/hreadyout_o=1; mem_we_o stays 0; the following read of 0x40 succeeds.
6. 4-beat INCR word write burst 0x100..0x10C (SEQ beats, one BUSY inserted), then read-back burst -> four consecutive RAM writes; the BUSY beat causes no access; all four values read back correctly.
